keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Scans a ROWSxCOLS matrix keypad by driving one column low at a time and reading the rows.
//  Synchronises and debounces the rows, then decodes the single pressed key into a key code.
//  Emits one event per press; no auto-repeat and no rollover.
//  Sits between the keypad pins and the display/key-history logic, replacing the old combinational decoder.
// PARAMETERS
//  ROWS        4        number of row inputs (2..8)
//  COLS        4        number of column outputs (2..8)
//  SCAN_DIV    1000     clk cycles per column dwell; must be >= 4
//  DEB_CYCLES  20000    consecutive stable samples needed to accept a press or a release; >= 2
//  HEX_MAP     1        1: use the package hex table (valid only when ROWS=COLS=4); 0: code = r*COLS+c
//  KEY_W       4        key_code width; must be >= $clog2(ROWS*COLS)
// PORTS
//  clk           in   1        system clock
//  reset_n       in   1        asynchronous active-low reset
//  row_n         in   ROWS     keypad rows, active-low, asynchronous (externally pulled up)
//  col_n         out  COLS     column drive, active-low one-hot
//  key_code      out  KEY_W    code of the last accepted key; holds its value until the next press
//  key_valid     out  1        1-cycle pulse when a press is accepted
//  key_held      out  1        high from acceptance of a press until its release is accepted
//  key_released  out  1        1-cycle pulse when a release is accepted
// BEHAVIOUR
//  - Reset: state=SCAN, col_idx=0, col_n=~1 (column 0 driven), key_code=0, key_valid=0,
//    key_held=0, key_released=0. All counters are 0; synchroniser flops are all 1.
//  - row_n passes through a 2-flop synchroniser (rs). All decisions use rs only.
//  - SCAN: dwell counter runs 0..SCAN_DIV-1 on column col_idx. At count SCAN_DIV-1, sample rs:
//    - exactly one bit low: capture row index r and c=col_idx, go to DEBOUNCE, keep the column.
//    - none or more than one bit low: col_idx advances; COLS-1 wraps to 0; dwell restarts.
//  - DEBOUNCE: each cycle compare rs against the captured pattern.
//    - On a match, increment; on the DEB_CYCLES-th consecutive match, go to HELD.
//      In that same edge, key_code=map(r,c), key_valid=1 and key_held=1.
//    - On any mismatch, return to SCAN on the same column with the dwell restarted. No event.
//  - HELD: the column stays driven. Only rs[r] is watched; other keys are ignored (no rollover).
//    - rs[r]=1 increments the release count; rs[r]=0 clears it.
//    - On the DEB_CYCLES-th consecutive high: key_released=1 and key_held=0, go to SCAN.
//      col_idx advances (with wrap).
//  - key_valid and key_released are never high in the same cycle.
//    Each is high exactly one cycle per event.
//  - Press latency: the last sampled dwell edge + DEB_CYCLES cycles, plus 2 synchroniser cycles.
//  - HEX_MAP=1 table: row0 = 1 2 3 C, row1 = 4 5 6 D, row2 = 7 8 9 E, row3 = A 0 B F.
//    Column 0 is the leftmost key in each row.
//  - Counters are sized $clog2(max(SCAN_DIV,DEB_CYCLES)+1) bits and must not wrap.
//  - Reset asserted mid-DEBOUNCE or mid-HELD returns everything to the reset values
//    immediately. No key_released pulse is issued.
// STRUCTURE
//  - Package keypad_pkg:
//    - state enum {SCAN, DEBOUNCE, HELD};
//    - KEYMAP_4X4 constant array [4][4] of 4-bit codes (table above);
//    - function onehot_count() for row-pattern checks.
//  - Sub-module keypad_keymap (combinational): (r, c) -> key_code, using HEX_MAP/linear selection.
//  - Top: synchroniser, dwell counter, debounce/release counter, FSM, output registers.
// TESTING (bench: SCAN_DIV=4, DEB_CYCLES=8, ROWS=COLS=4, HEX_MAP=1)
//  1. Assert reset_n=0 mid-run -> col_n=4'b1110, key_code=0, all pulses 0. Release reset, no key pressed
//     -> col_n cycles 1110,1101,1011,0111,1110, with 4 cycles per column.
//  2. Hold row1 low only while col_n=1101, for 200 cycles -> one key_valid pulse with key_code=4'h5.
//     key_held=1 throughout the press. Releasing it gives one key_released pulse 8 stable cycles later.
//  3. Hold row0 low 5 cycles then release, repeated (bounce) -> no key_valid. Then hold stable
//     -> key_valid with key_code=4'h1.
//  4. Drive rows 0 and 2 low together on column 0 -> no key_valid. Scanning continues to column 1.
//  5. Hold key 8 (row2/col1); while held, also press key 3 -> no second key_valid.
//     Release key 8 -> key_released. With key 3 still down, the next scan yields key_valid, code 4'h3.
//  6. Assert reset_n mid-DEBOUNCE and, separately, during HELD -> outputs take reset values at once,
//     with no key_released. Scanning restarts at column 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, the 4x4 hex key table and row-pattern helpers for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    // Indexed [row][col]; column 0 is the leftmost key of each row.
    localparam logic [3:0] KEYMAP_4X4 [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hC},
        '{4'h4, 4'h5, 4'h6, 4'hD},
        '{4'h7, 4'h8, 4'h9, 4'hE},
        '{4'hA, 4'h0, 4'hB, 4'hF}
    };

    // Number of set bits; callers pass the active-high "row is low" pattern, zero padded.
    function automatic int unsigned onehot_count(input logic [7:0] bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n = n + {31'b0, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/keypad_keymap.sv
// Translates a (row, column) key position into the reported key code.
module keypad_keymap
    import keypad_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int HEX_MAP = 1,
    parameter int KEY_W   = 4
) (
    input  logic [$clog2(ROWS)-1:0] row_idx,
    input  logic [$clog2(COLS)-1:0] col_idx,
    output logic [KEY_W-1:0]        key_code
);

    generate
        if (HEX_MAP != 0) begin : g_hex
            // Calculator-style hex layout; only meaningful for a 4x4 pad.
            assign key_code = KEY_W'(KEYMAP_4X4[row_idx[1:0]][col_idx[1:0]]);
        end else begin : g_lin
            // Row-major linear numbering.
            assign key_code = KEY_W'(32'(row_idx) * COLS + 32'(col_idx));
        end
    endgenerate

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column strobe, row synchroniser, press/release debounce and key events.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 20000,
    parameter int HEX_MAP    = 1,
    parameter int KEY_W      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ROWS-1:0]   row_n,
    output logic [COLS-1:0]   col_n,
    output logic [KEY_W-1:0]  key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              key_released
);

    localparam int RW      = $clog2(ROWS);
    localparam int CW      = $clog2(COLS);
    localparam int CNT_MAX = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CW-1:0]    COL_LAST   = CW'(COLS - 1);

    logic [ROWS-1:0]  rs_meta_q, rs_q;
    logic [ROWS-1:0]  rs_low;
    state_e           state_q, state_d;
    logic [CW-1:0]    col_idx_q, col_idx_d, col_next;
    logic [RW-1:0]    row_idx_q, row_idx_d, low_row;
    logic [ROWS-1:0]  pattern_q, pattern_d;
    logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [KEY_W-1:0] key_code_q, key_code_d, map_code;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic             key_released_q, key_released_d;
    logic             one_low, dwell_done, rs_match, press_done, release_done;

    // Two-flop synchroniser on the asynchronous rows; idle (released) level is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs_meta_q <= '1;
            rs_q      <= '1;
        end else begin
            rs_meta_q <= row_n;
            rs_q      <= rs_meta_q;
        end
    end

    assign rs_low       = ~rs_q;
    assign one_low      = (onehot_count(8'(rs_low)) == 1);
    assign dwell_done   = (dwell_cnt_q == DWELL_LAST);
    assign rs_match     = (rs_q == pattern_q);
    assign press_done   = rs_match && (deb_cnt_q == DEB_LAST);
    assign release_done = rs_q[row_idx_q] && (deb_cnt_q == DEB_LAST);
    assign col_next     = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;

    // Index of the low row; only consulted when exactly one row is low.
    always_comb begin
        low_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (rs_low[i]) low_row = RW'(i);
        end
    end

    // Column drive decoded straight from the column register, so reset drives column 0 at once.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col
            assign col_n[gi] = (col_idx_q != CW'(gi));
        end
    endgenerate

    keypad_keymap #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .HEX_MAP (HEX_MAP),
        .KEY_W   (KEY_W)
    ) u_keymap (
        .row_idx  (row_idx_q),
        .col_idx  (col_idx_q),
        .key_code (map_code)
    );

    // State, counters, captured key position and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= SCAN;
            col_idx_q      <= '0;
            row_idx_q      <= '0;
            pattern_q      <= '1;
            dwell_cnt_q    <= '0;
            deb_cnt_q      <= '0;
            key_code_q     <= '0;
            key_valid_q    <= 1'b0;
            key_held_q     <= 1'b0;
            key_released_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_idx_q      <= col_idx_d;
            row_idx_q      <= row_idx_d;
            pattern_q      <= pattern_d;
            dwell_cnt_q    <= dwell_cnt_d;
            deb_cnt_q      <= deb_cnt_d;
            key_code_q     <= key_code_d;
            key_valid_q    <= key_valid_d;
            key_held_q     <= key_held_d;
            key_released_q <= key_released_d;
        end
    end

    // Next state: dwell per column, capture a single-key pattern, debounce press and release.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        pattern_d   = pattern_q;
        dwell_cnt_d = dwell_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        case (state_q)
            SCAN: begin
                if (dwell_done) begin
                    dwell_cnt_d = '0;
                    if (one_low) begin
                        state_d   = DEBOUNCE;
                        row_idx_d = low_row;
                        pattern_d = rs_q;
                        deb_cnt_d = '0;
                    end else begin
                        col_idx_d = col_next;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!rs_match) begin
                    // Bounce: retry the same column from a fresh dwell.
                    state_d     = SCAN;
                    dwell_cnt_d = '0;
                    deb_cnt_d   = '0;
                end else if (press_done) begin
                    state_d   = HELD;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            HELD: begin
                // Only the captured row matters here; other keys are ignored.
                if (!rs_q[row_idx_q]) begin
                    deb_cnt_d = '0;
                end else if (release_done) begin
                    state_d     = SCAN;
                    deb_cnt_d   = '0;
                    dwell_cnt_d = '0;
                    col_idx_d   = col_next;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // Output events: one-cycle pulses on press/release acceptance, held level and latched code.
    always_comb begin
        key_valid_d    = 1'b0;
        key_released_d = 1'b0;
        key_held_d     = key_held_q;
        key_code_d     = key_code_q;
        case (state_q)
            DEBOUNCE: begin
                if (press_done) begin
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    key_code_d  = map_code;
                end
            end
            HELD: begin
                if (release_done) begin
                    key_released_d = 1'b1;
                    key_held_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign key_code     = key_code_q;
    assign key_valid    = key_valid_q;
    assign key_held     = key_held_q;
    assign key_released = key_released_q;

endmodule
